gf180mcu_fd_sc_mcu9t5v0__muxsel_ctl: RTL and testbench

select sequencer driving the S pin of the downstream mux2 cell. Enforces a minimum dwell between select changes and a settle window, with a request/acknowledge handshake.

Interface
REQ-001 Parameter SETTLE, default 2, meaning: cycles S is held not-valid after a change (legal range 1..15).
REQ-002 Parameter DWELL, default 4, meaning: minimum cycles between completion of one switch and the next S change (legal range 0..15).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 CLK  input  1  rising-edge clock; all state updates on this edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 REQ  input  1  request to set S to TGT; sampled only when BUSY=0.
REQ-007 TGT  input  1  requested select value; latched with an accepted REQ.
REQ-008 S    output 1  registered select to downstream mux2 S pin.
REQ-009 SV   output 1  high when S is settled and valid.
REQ-010 BUSY output 1  high while a request is in progress; new REQ ignored.
REQ-011 ACK  output 1  one-cycle pulse on request completion.

Function
REQ-012 All outputs SHALL be registered; there SHALL be no combinational input-to-output path.
REQ-013 The FSM SHALL have the states IDLE, HOLD, and SWITCH.
REQ-014 The block SHALL keep a dwell counter DW (4 bits) and a settle counter SC (4 bits).
REQ-015 DW SHALL increment at each edge while the state is not SWITCH and DW<DWELL, and SHALL saturate at DWELL.
REQ-016 In IDLE with REQ=1 and TGT==S, the block SHALL assert ACK for the next cycle and leave S, SV, BUSY and DW unchanged.
REQ-017 In IDLE with REQ=1, TGT!=S and DW==DWELL, the block SHALL load S<=TGT, SV<=0, BUSY<=1, SC<=0 and enter SWITCH.
REQ-018 In IDLE with REQ=1, TGT!=S and DW<DWELL, the block SHALL latch TGT, set BUSY<=1 and enter HOLD; S is unchanged.
REQ-019 In HOLD, at the first edge where DW==DWELL (value before the edge), the block SHALL load S<=latched TGT, SV<=0, SC<=0 and enter SWITCH.
REQ-020 In SWITCH, SC SHALL increment each edge; at the edge where SC==SETTLE-1, the block SHALL set SV<=1, BUSY<=0, ACK<=1, DW<=0 and enter IDLE.
REQ-021 S SHALL change exactly SETTLE edges before ACK rises, and SV SHALL be 0 for exactly SETTLE cycles per switch.
REQ-022 ACK SHALL be high for exactly one cycle per accepted REQ.
REQ-023 REQ and TGT SHALL be ignored while BUSY=1, including in the ACK cycle's preceding SWITCH edge.
REQ-024 With DWELL=0, HOLD SHALL never be entered.
REQ-025 REQ held high continuously SHALL be treated as a new request at each IDLE edge where BUSY=0.

Reset
REQ-026 While RST=1 at an edge, the block SHALL set S=0, SV=1, BUSY=0, ACK=0, SC=0, DW=DWELL and state IDLE.
REQ-027 RST SHALL override all other inputs and abort any HOLD or SWITCH in progress with no ACK.
REQ-028 After reset, the first request with TGT!=S SHALL switch immediately, with no dwell wait.

Verification (SETTLE=2, DWELL=4, edges numbered after reset release)
REQ-029 Reset then REQ=1,TGT=1 at edge 1 -> S=1 and SV=0, BUSY=1 after edge 1; SV=1, ACK=1, BUSY=0 after edge 3; ACK=0 after edge 4.
REQ-030 Following REQ-029, REQ=1,TGT=0 at edge 4 -> HOLD with BUSY=1 and S=1 through edge 7; S=0 after edge 8; ACK=1 after edge 10.
REQ-031 In IDLE with S=0, REQ=1,TGT=0 -> ACK=1 for one cycle after the edge; S=0, SV=1 and BUSY=0 throughout.
REQ-032 REQ=1,TGT=0 at edge 2 during the switch of REQ-029 -> no effect; exactly one ACK occurs (after edge 3) and S stays 1.
REQ-033 RST=1 at edge 2 during SWITCH -> S=0, SV=1, BUSY=0 after edge 2 with no ACK; then REQ=1,TGT=1 at edge 3 gives S=1 after edge 3 with no HOLD.
REQ-034 Build with DWELL=0 and issue back-to-back toggling requests -> HOLD is never entered and ACK occurs every SETTLE+1 cycles.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__muxsel_ctl.sv | 181 ++++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__muxsel_ctl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__muxsel_ctl.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__muxsel_ctl
//
// Select sequencer for the S pin of a downstream mux2 cell. A request asks for
// S to take the value TGT. The block enforces a minimum dwell time after each
// completed switch before S may change again. After each change it holds SV low
// for a settle window. Each accepted request ends with a one-cycle ACK pulse.
//
// Parameters
//   SETTLE : cycles S is reported not-valid after a change (1..15)
//   DWELL  : minimum cycles from completion of one switch to the next S change
//            (0..15)
//
// Ports
//   CLK  : rising-edge clock
//   RST  : synchronous, active-high reset
//   REQ  : request to drive S to TGT (sampled only while BUSY is low)
//   TGT  : requested select value, captured together with an accepted REQ
//   S    : registered select to the mux2 S pin
//   SV   : high while S is settled and valid
//   BUSY : high while a request is in progress (REQ is ignored)
//   ACK  : one-cycle pulse when a request completes
//
// All outputs come straight from flops. No combinational path runs from the
// inputs to the outputs.
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__muxsel_ctl #(
  parameter int SETTLE = 2,
  parameter int DWELL  = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ,
  input  logic TGT,
  output logic S,
  output logic SV,
  output logic BUSY,
  output logic ACK
);

  // Catch illegal parameter choices at elaboration time.
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("SETTLE must be in 1..15");
  end
  if (DWELL < 0 || DWELL > 15) begin : g_bad_dwell
    $error("DWELL must be in 0..15");
  end

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;  // waiting for a request
  localparam logic [1:0] ST_HOLD   = 2'd1;  // request latched, dwell not yet met
  localparam logic [1:0] ST_SWITCH = 2'd2;  // S changed, settle window running

  // 4-bit versions of the parameters for width-matched compares.
  localparam logic [3:0] DWELL_MAX = 4'(DWELL);
  localparam logic [3:0] SC_LAST   = 4'(SETTLE - 1);

  // Registered state
  logic [1:0] state_q, state_d;
  logic [3:0] dw_q,    dw_d;     // dwell counter, saturates at DWELL
  logic [3:0] sc_q,    sc_d;     // settle counter while in SWITCH
  logic       tgt_q,   tgt_d;    // target captured on entry to HOLD
  logic       s_q,     s_d;
  logic       sv_q,    sv_d;
  logic       busy_q,  busy_d;
  logic       ack_q,   ack_d;

  // DW only counts up to DWELL and is reset to 0 on completion. It therefore
  // never exceeds DWELL, so an equality test is enough to detect saturation.
  logic dw_sat;
  assign dw_sat = (dw_q == DWELL_MAX);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    sc_d    = sc_q;
    tgt_d   = tgt_q;
    s_d     = s_q;
    sv_d    = sv_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;     // ACK is a pulse: low unless set this cycle

    // Dwell counts everywhere except during the settle window.
    if (state_q != ST_SWITCH && !dw_sat) begin
      dw_d = dw_q + 4'd1;
    end else begin
      dw_d = dw_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          if (TGT == s_q) begin
            // Already there: acknowledge without touching S or SV.
            ack_d = 1'b1;
          end else if (dw_sat) begin
            // Dwell already met: switch on this edge.
            s_d     = TGT;
            sv_d    = 1'b0;
            busy_d  = 1'b1;
            sc_d    = 4'd0;
            state_d = ST_SWITCH;
          end else begin
            // Too soon after the last switch: park the target until the
            // dwell counter catches up.
            tgt_d   = TGT;
            busy_d  = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // REQ/TGT are ignored here. Only the dwell counter moves us on.
        if (dw_sat) begin
          s_d     = tgt_q;
          sv_d    = 1'b0;
          sc_d    = 4'd0;
          state_d = ST_SWITCH;
        end
      end

      ST_SWITCH: begin
        sc_d = sc_q + 4'd1;
        // S changed on the edge that entered SWITCH. That edge plus SETTLE-1
        // counted edges gives exactly SETTLE edges before ACK rises.
        if (sc_q == SC_LAST) begin
          sv_d    = 1'b1;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          dw_d    = 4'd0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a quiet, valid idle.
        sv_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers (synchronous reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (RST) begin
      state_q <= ST_IDLE;
      dw_q    <= DWELL_MAX;   // first request after reset needs no dwell wait
      sc_q    <= 4'd0;
      tgt_q   <= 1'b0;
      s_q     <= 1'b0;
      sv_q    <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dw_q    <= dw_d;
      sc_q    <= sc_d;
      tgt_q   <= tgt_d;
      s_q     <= s_d;
      sv_q    <= sv_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign S    = s_q;
  assign SV   = sv_q;
  assign BUSY = busy_q;
  assign ACK  = ack_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__muxsel_ctl.sv
// -----------------------------------------------------------------------------
// Testbench for gf180mcu_fd_sc_mcu9t5v0__muxsel_ctl.
// dut_a uses the defaults (SETTLE=2, DWELL=4) and is checked through a
// scoreboard. dut_b is built with DWELL=0 and checked against a fixed
// back-to-back schedule.
// -----------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu9t5v0__muxsel_ctl;

  localparam int SETTLE = 2;
  localparam int DWELL  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0, tgt = 1'b0;
  logic s, sv, busy, ack;
  logic req_b = 1'b0, tgt_b = 1'b0;
  logic s_b, sv_b, busy_b, ack_b;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__muxsel_ctl #(.SETTLE(SETTLE), .DWELL(DWELL)) dut_a (
    .CLK(clk), .RST(rst), .REQ(req), .TGT(tgt),
    .S(s), .SV(sv), .BUSY(busy), .ACK(ack)
  );

  gf180mcu_fd_sc_mcu9t5v0__muxsel_ctl #(.SETTLE(SETTLE), .DWELL(0)) dut_b (
    .CLK(clk), .RST(rst), .REQ(req_b), .TGT(tgt_b),
    .S(s_b), .SV(sv_b), .BUSY(busy_b), .ACK(ack_b)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Edge counter: 0 on a reset edge, then 1, 2, ... after release.
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
  end

  // One scoreboard entry per accepted request (all edge numbers use cyc).
  typedef struct {
    int   rq;     // edge that samples the request
    int   sw;     // edge at which S changes (-1: no change)
    int   ack;    // edge after which ACK is high
    logic s_old;
    logic s_new;
  } exp_t;

  exp_t sb[$];
  int   pend_ack  = -1;     // ACK edge of the newest accepted request
  int   last_done = -100;   // last completing edge of a real switch
  logic s_model   = 1'b0;
  bit   mon_en    = 1'b0;

  // Drive one request for one edge. The expectation is derived from the
  // timing rules: the request is accepted only after the previous ACK edge.
  // The switch edge is the first edge at which the dwell since the last
  // completion is met, and ACK follows SETTLE edges later.
  task automatic drive_req(input logic t);
    int   e;
    exp_t x;
    req = 1'b1;
    tgt = t;
    e   = cyc + 1;
    if (e > pend_ack) begin
      x.rq    = e;
      x.s_old = s_model;
      if (t == s_model) begin
        x.sw     = -1;
        x.ack    = e;
        x.s_new  = s_model;
        pend_ack = e;
      end else begin
        x.sw      = (e > last_done + DWELL + 1) ? e : last_done + DWELL + 1;
        x.ack     = x.sw + SETTLE;
        x.s_new   = t;
        pend_ack  = x.ack;
        last_done = x.ack;
        s_model   = t;
      end
      sb.push_back(x);
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    pend_ack  = -1;
    last_done = -100;
    s_model   = 1'b0;
    @(negedge clk);
    check("rst_s",    s,    0);
    check("rst_sv",   sv,   1);
    check("rst_busy", busy, 0);
    check("rst_ack",  ack,  0);
    check("rst_b_s",  s_b,  0);
    check("rst_b_sv", sv_b, 1);
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor for dut_a: compare against the front scoreboard entry each cycle.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (sb.size() == 0) begin
        check("ack_idle", ack, 0);
      end else begin
        exp_t f;
        f = sb[0];
        if (cyc >= f.rq) begin
          if (f.sw >= 0 && cyc < f.sw) begin
            check("hold_busy", busy, 1);
            check("hold_s", s, f.s_old);
          end
          if (f.sw >= 0 && cyc >= f.sw && cyc < f.ack) begin
            check("settle_s", s, f.s_new);
            check("settle_sv", sv, 0);
            check("settle_busy", busy, 1);
            check("settle_ack", ack, 0);
          end
          if (cyc == f.ack) begin
            check("ack_pulse", ack, 1);
            check("ack_s", s, f.s_new);
            check("ack_sv", sv, 1);
            check("ack_busy", busy, 0);
            void'(sb.pop_front());
          end else if (cyc > f.ack) begin
            check("ack_timeout", cyc, f.ack);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();

    // First switch after reset is immediate; a request during SWITCH and one
    // on the completion edge are ignored.
    drive_req(1'b1);   // edge 1
    drive_req(1'b0);   // edge 2, ignored
    drive_req(1'b0);   // edge 3, ignored (completion edge)
    // Dwell not met: HOLD until edge 8, ACK after edge 10.
    drive_req(1'b0);   // edge 4
    drive_req(1'b1);   // edge 5, ignored (HOLD)
    idle(8);
    // Same-target requests held high: ACK on consecutive cycles, S untouched.
    drive_req(1'b0);
    drive_req(1'b0);
    // Immediate switch after long idle, then one short of dwell.
    drive_req(1'b1);
    idle(2);
    drive_req(1'b0);
    idle(8);

    // Reset aborts a switch in progress, then the next request is immediate.
    do_reset();
    drive_req(1'b1);   // edge 1 enters SWITCH
    do_reset();        // reset edge aborts it, no ACK
    drive_req(1'b1);   // immediate switch again
    idle(4);

    // DWELL=0 instance: REQ held high with the target toggling every
    // SETTLE+1 edges, so each request lands on the cycle after the ACK.
    do_reset();
    for (int e = 1; e <= 15; e++) begin
      tgt_b = (((e - 1) / 3) % 2 == 0);
      req_b = 1'b1;
      @(negedge clk);
      check("b_ack",  ack_b,  (e % 3 == 0));
      check("b_busy", busy_b, (e % 3 != 0));
      check("b_s",    s_b,    (((e - 1) / 3) % 2 == 0));
      check("b_sv",   sv_b,   (e % 3 == 0));
    end
    req_b = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
